rf_nrsw: RTL

Parametrised N-read, single-write register file: the successor to the dual-read/single-write regfile interface used by the core. It generalises read-port count and width, registers read data with write-first bypass, optionally hardwires entry 0 to zero, and adds a hardware clear sequencer. The sequencer sweeps every entry to zero after reset or on request. The block sits between the decode/operand-fetch stage and writeback of the multi-cycle core.

---
 rtl/rf_nrsw_pkg.sv | 10 +
 rtl/rf_nrsw_if.sv | 27 ++
 rtl/rf_nrsw_clr_seq.sv | 58 +++++
 rtl/rf_nrsw.sv | 86 ++++++++
 4 files changed

// File: rtl/rf_nrsw_pkg.sv
// Shared types and helpers for the N-read / single-write register file.
package rf_pkg;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_clr_state_t;

  function automatic int rf_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/rf_nrsw_if.sv
// Bundle between operand-fetch/writeback (to_rf) and the register file (from_rf).
interface rf_nrsw_intf #(
  parameter int addr_w = 5,
  parameter int data_w = 32,
  parameter int n_rd   = 2
);

  logic                     RdWe;
  logic [addr_w-1:0]        RdAddr;
  logic [data_w-1:0]        RdData;
  logic [n_rd-1:0]          RsRe;
  logic [n_rd*addr_w-1:0]   RsAddr;
  logic [n_rd*data_w-1:0]   RsData;
  logic                     ClrReq;
  logic                     Busy;

  modport to_rf (
    output RdWe, RdAddr, RdData, RsRe, RsAddr, ClrReq,
    input  RsData, Busy
  );

  modport from_rf (
    input  RdWe, RdAddr, RdData, RsRe, RsAddr, ClrReq,
    output RsData, Busy
  );

endinterface

// File: rtl/rf_nrsw_clr_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or on ClrReq.
module rf_clr_seq
  import rf_pkg::*;
#(
  parameter int addr_w = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ClrReq,
  output logic              Busy,
  output logic              ClrWe,
  output logic [addr_w-1:0] ClrAddr
);

  rf_clr_state_t     state, state_nxt;
  logic [addr_w-1:0] cnt, cnt_nxt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= RF_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The last entry is depth-1, i.e. all ones; requests mid-sweep are ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RF_CLEAR: begin
        if (cnt == '1) begin
          state_nxt = RF_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + addr_w'(1);
        end
      end
      RF_IDLE: begin
        if (ClrReq) begin
          state_nxt = RF_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RF_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign Busy    = (state == RF_CLEAR);
  assign ClrWe   = Busy;
  assign ClrAddr = cnt;

endmodule

// File: rtl/rf_nrsw.sv
// N-read / single-write register file with registered, write-first read ports
// and a hardware clear sweep that owns the write path while Busy is high.
module rf_nrsw
  import rf_pkg::*;
#(
  parameter int addr_w   = 5,
  parameter int data_w   = 32,
  parameter int n_rd     = 2,
  parameter bit zero_reg = 1'b1
) (
  input logic          Clk,
  input logic          Rst,
  rf_nrsw_intf.from_rf bus
);

  localparam int depth = rf_depth(addr_w);

  logic [data_w-1:0] mem [depth];

  logic              busy;
  logic              clr_we;
  logic [addr_w-1:0] clr_addr;
  logic              wr_en;
  logic [addr_w-1:0] wr_addr;
  logic [data_w-1:0] wr_data;

  rf_clr_seq #(.addr_w(addr_w)) u_clr_seq (
    .Clk     (Clk),
    .Rst     (Rst),
    .ClrReq  (bus.ClrReq),
    .Busy    (busy),
    .ClrWe   (clr_we),
    .ClrAddr (clr_addr)
  );

  assign bus.Busy = busy;

  // User writes are dropped, not queued, while the sweep owns the array.
  always_comb begin
    wr_en   = bus.RdWe && !(zero_reg && (bus.RdAddr == '0));
    wr_addr = bus.RdAddr;
    wr_data = bus.RdData;
    if (busy) begin
      wr_en   = clr_we;
      wr_addr = clr_addr;
      wr_data = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < n_rd; i++) begin : g_rd
    logic [addr_w-1:0] ra;
    logic [data_w-1:0] sel;
    logic [data_w-1:0] q;

    assign ra = bus.RsAddr[i*addr_w +: addr_w];

    // Busy beats the hardwired zero, which beats the same-cycle write bypass.
    always_comb begin
      sel = mem[ra];
      if (busy) begin
        sel = '0;
      end else if (zero_reg && (ra == '0)) begin
        sel = '0;
      end else if (bus.RdWe && (bus.RdAddr == ra)) begin
        sel = bus.RdData;
      end
    end

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        q <= '0;
      end else if (bus.RsRe[i]) begin
        q <= sel;
      end
    end

    assign bus.RsData[i*data_w +: data_w] = q;
  end

endmodule
